multicycle_control_fsm: RTL

- Main control state machine for the multicycle RV32I core.
- Drives the 2-bit select lines of the datapath's 4:1 operand/result multiplexers (alu_src_a, alu_src_b, result_src) and the register/memory write enables.
- Sequences fetch, decode, execute, memory and writeback one state per clock, stalling on memory handshake.

---
 rtl/multicycle_control_fsm_if.sv | 34 +++
 rtl/multicycle_control_fsm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle RV32I main FSM and its datapath.
// The master is the FSM and the slave is the datapath.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] alu_op;
  logic       instr_retire;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_op,
           instr_retire, illegal_op, state
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_op,
           instr_retire, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: one state per clock,
// with outputs decoded combinationally from the current state.
module multicycle_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  multicycle_control_fsm_if.master        bus
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned ST_W  = 4;

  localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I     = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_BR    = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;

  typedef enum logic [ST_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_CALC = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   ready;

  assign ready     = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  assign bus.state = ST_W'(state_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d          = S_FETCH;
    bus.pc_write     = 1'b0;
    bus.adr_src      = 1'b0;
    bus.mem_write    = 1'b0;
    bus.ir_write     = 1'b0;
    bus.reg_write    = 1'b0;
    bus.alu_src_a    = 2'b00;
    bus.alu_src_b    = 2'b00;
    bus.result_src   = 2'b00;
    bus.alu_op       = 2'b00;
    bus.instr_retire = 1'b0;
    bus.illegal_op   = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = ready;
        bus.pc_write   = ready;
        state_d        = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_CALC;
          OP_LUI:            state_d = S_LUI;
          default: begin
            bus.illegal_op   = 1'b1;
            bus.instr_retire = 1'b1;
            state_d          = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_d       = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        state_d     = ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        bus.result_src   = 2'b01;
        bus.reg_write    = 1'b1;
        bus.instr_retire = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.adr_src      = 1'b1;
        bus.mem_write    = 1'b1;
        bus.instr_retire = ready;
        state_d          = ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
        state_d       = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write    = 1'b1;
        bus.instr_retire = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a    = 2'b10;
        bus.alu_op       = 2'b01;
        bus.instr_retire = 1'b1;
        bus.pc_write     = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                           ((bus.funct3 == 3'b001) && !bus.zero);
        state_d          = S_FETCH;
      end
      // JAL and JALR_LINK redirect the PC and stage OldPC+4 for the link write
      S_JAL, S_JALR_LINK: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        state_d       = S_ALUWB;
      end
      S_JALR_CALC: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_d       = S_JALR_LINK;
      end
      S_LUI: begin
        bus.alu_src_a = 2'b11;
        bus.alu_src_b = 2'b01;
        state_d       = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset holds the FETCH selects but must never let a write enable through
    if (reset) begin
      bus.pc_write     = 1'b0;
      bus.ir_write     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.reg_write    = 1'b0;
      bus.instr_retire = 1'b0;
      bus.illegal_op   = 1'b0;
    end
  end

endmodule
